// File: rtl/bypass_nf_back.sv
// Packet-granular merge of the NF and bypass stream triplets (pkt/meta/usr) into one egress triplet.
// Define BYPASS_MERGE_RR_EN for round-robin arbitration; otherwise NF has strict priority.

package struct_s;
  typedef struct packed {
    logic [31:0] flow_id;
    logic [15:0] pkt_len;
    logic [7:0]  in_port;
    logic [7:0]  out_port;
    logic [63:0] tstamp;
  } metadata_t;
endpackage

module bypass_nf_back
  import struct_s::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [511:0]    nf_pkt_data,
  input  logic            nf_pkt_valid,
  input  logic            nf_pkt_sop,
  input  logic            nf_pkt_eop,
  input  logic [5:0]      nf_pkt_empty,
  output logic            nf_pkt_ready,
  input  metadata_t       nf_meta_data,
  input  logic            nf_meta_valid,
  output logic            nf_meta_ready,
  input  logic [511:0]    nf_usr_data,
  input  logic            nf_usr_valid,
  input  logic            nf_usr_sop,
  input  logic            nf_usr_eop,
  input  logic [5:0]      nf_usr_empty,
  output logic            nf_usr_ready,
  input  logic [511:0]    bypass_pkt_data,
  input  logic            bypass_pkt_valid,
  input  logic            bypass_pkt_sop,
  input  logic            bypass_pkt_eop,
  input  logic [5:0]      bypass_pkt_empty,
  output logic            bypass_pkt_ready,
  input  metadata_t       bypass_meta_data,
  input  logic            bypass_meta_valid,
  output logic            bypass_meta_ready,
  input  logic [511:0]    bypass_usr_data,
  input  logic            bypass_usr_valid,
  input  logic            bypass_usr_sop,
  input  logic            bypass_usr_eop,
  input  logic [5:0]      bypass_usr_empty,
  output logic            bypass_usr_ready,
  output logic [511:0]    out_pkt_data,
  output logic            out_pkt_valid,
  output logic            out_pkt_sop,
  output logic            out_pkt_eop,
  output logic [5:0]      out_pkt_empty,
  input  logic            out_pkt_almost_full,
  output metadata_t       out_meta_data,
  output logic            out_meta_valid,
  input  logic            out_meta_almost_full,
  output logic [511:0]    out_usr_data,
  output logic            out_usr_valid,
  output logic            out_usr_sop,
  output logic            out_usr_eop,
  output logic [5:0]      out_usr_empty,
  input  logic            out_usr_almost_full,
  output logic [31:0]     nf_pkt_cnt,
  output logic [31:0]     bypass_pkt_cnt
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] MERGE = 1'b1;

  logic [0:0]  state_r;
  logic        sel_r;
  logic        pkt_done_r;
  logic        meta_done_r;
  logic        usr_done_r;
  logic [31:0] nf_cnt_r;
  logic [31:0] bypass_cnt_r;
`ifdef BYPASS_MERGE_RR_EN
  logic        rr_ptr_r;
`endif

  logic        in_merge_s;
  logic        all_done_s;
  logic        start_s;
  logic        pick_s;
  logic        pkt_rdy_s;
  logic        meta_rdy_s;
  logic        usr_rdy_s;
  logic        pkt_xfer_s;
  logic        meta_xfer_s;
  logic        usr_xfer_s;

  // sel_r steers every source-side mux below
  logic [511:0] sel_pkt_data_s;
  logic         sel_pkt_valid_s;
  logic         sel_pkt_sop_s;
  logic         sel_pkt_eop_s;
  logic [5:0]   sel_pkt_empty_s;
  metadata_t    sel_meta_data_s;
  logic         sel_meta_valid_s;
  logic [511:0] sel_usr_data_s;
  logic         sel_usr_valid_s;
  logic         sel_usr_sop_s;
  logic         sel_usr_eop_s;
  logic [5:0]   sel_usr_empty_s;

  assign sel_pkt_data_s   = sel_r ? bypass_pkt_data   : nf_pkt_data;
  assign sel_pkt_valid_s  = sel_r ? bypass_pkt_valid  : nf_pkt_valid;
  assign sel_pkt_sop_s    = sel_r ? bypass_pkt_sop    : nf_pkt_sop;
  assign sel_pkt_eop_s    = sel_r ? bypass_pkt_eop    : nf_pkt_eop;
  assign sel_pkt_empty_s  = sel_r ? bypass_pkt_empty  : nf_pkt_empty;
  assign sel_meta_data_s  = sel_r ? bypass_meta_data  : nf_meta_data;
  assign sel_meta_valid_s = sel_r ? bypass_meta_valid : nf_meta_valid;
  assign sel_usr_data_s   = sel_r ? bypass_usr_data   : nf_usr_data;
  assign sel_usr_valid_s  = sel_r ? bypass_usr_valid  : nf_usr_valid;
  assign sel_usr_sop_s    = sel_r ? bypass_usr_sop    : nf_usr_sop;
  assign sel_usr_eop_s    = sel_r ? bypass_usr_eop    : nf_usr_eop;
  assign sel_usr_empty_s  = sel_r ? bypass_usr_empty  : nf_usr_empty;

  assign in_merge_s = (state_r == MERGE);
  assign all_done_s = pkt_done_r & meta_done_r & usr_done_r;
  assign start_s    = (state_r == IDLE) & (nf_pkt_valid | bypass_pkt_valid);

  // almost_full and rst gate ready combinationally so no beat is taken in a reset cycle
  assign pkt_rdy_s  = in_merge_s & ~pkt_done_r  & ~out_pkt_almost_full  & ~rst;
  assign meta_rdy_s = in_merge_s & ~meta_done_r & ~out_meta_almost_full & ~rst;
  assign usr_rdy_s  = in_merge_s & ~usr_done_r  & ~out_usr_almost_full  & ~rst;

  assign nf_pkt_ready      = pkt_rdy_s  & ~sel_r;
  assign nf_meta_ready     = meta_rdy_s & ~sel_r;
  assign nf_usr_ready      = usr_rdy_s  & ~sel_r;
  assign bypass_pkt_ready  = pkt_rdy_s  & sel_r;
  assign bypass_meta_ready = meta_rdy_s & sel_r;
  assign bypass_usr_ready  = usr_rdy_s  & sel_r;

  assign pkt_xfer_s  = pkt_rdy_s  & sel_pkt_valid_s;
  assign meta_xfer_s = meta_rdy_s & sel_meta_valid_s;
  assign usr_xfer_s  = usr_rdy_s  & sel_usr_valid_s;

  assign nf_pkt_cnt     = nf_cnt_r;
  assign bypass_pkt_cnt = bypass_cnt_r;

  // Source choice for the next packet, evaluated while IDLE
  always_comb begin
    pick_s = 1'b0;
`ifdef BYPASS_MERGE_RR_EN
    if (nf_pkt_valid && bypass_pkt_valid) begin
      pick_s = rr_ptr_r;
    end else if (nf_pkt_valid) begin
      pick_s = 1'b0;
    end else begin
      pick_s = 1'b1;
    end
`else
    if (nf_pkt_valid) begin
      pick_s = 1'b0;
    end else begin
      pick_s = 1'b1;
    end
`endif
  end

  // Packet lock FSM and per-stream completion flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      sel_r       <= 1'b0;
      pkt_done_r  <= 1'b0;
      meta_done_r <= 1'b0;
      usr_done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          pkt_done_r  <= 1'b0;
          meta_done_r <= 1'b0;
          usr_done_r  <= 1'b0;
          if (start_s) begin
            sel_r   <= pick_s;
            state_r <= MERGE;
          end
        end
        MERGE: begin
          if (pkt_xfer_s && sel_pkt_eop_s) pkt_done_r <= 1'b1;
          if (meta_xfer_s) meta_done_r <= 1'b1;
          if (usr_xfer_s && sel_usr_eop_s) usr_done_r <= 1'b1;
          if (all_done_s) state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Completed-packet counters, free-running wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      nf_cnt_r     <= 32'd0;
      bypass_cnt_r <= 32'd0;
    end else if (in_merge_s && all_done_s) begin
      if (sel_r) bypass_cnt_r <= bypass_cnt_r + 32'd1;
      else       nf_cnt_r     <= nf_cnt_r + 32'd1;
    end
  end

`ifdef BYPASS_MERGE_RR_EN
  // Favour the source not served by the packet that just completed
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r <= 1'b0;
    end else if (in_merge_s && all_done_s) begin
      rr_ptr_r <= ~sel_r;
    end
  end
`endif

  // Output valids: one cycle after each transferred beat
  always_ff @(posedge clk) begin
    if (rst) begin
      out_pkt_valid  <= 1'b0;
      out_meta_valid <= 1'b0;
      out_usr_valid  <= 1'b0;
    end else begin
      out_pkt_valid  <= pkt_xfer_s;
      out_meta_valid <= meta_xfer_s;
      out_usr_valid  <= usr_xfer_s;
    end
  end

  // Output payload registers, loaded only on transfer
  always_ff @(posedge clk) begin
    if (pkt_xfer_s) begin
      out_pkt_data  <= sel_pkt_data_s;
      out_pkt_sop   <= sel_pkt_sop_s;
      out_pkt_eop   <= sel_pkt_eop_s;
      out_pkt_empty <= sel_pkt_empty_s;
    end
    if (meta_xfer_s) begin
      out_meta_data <= sel_meta_data_s;
    end
    if (usr_xfer_s) begin
      out_usr_data  <= sel_usr_data_s;
      out_usr_sop   <= sel_usr_sop_s;
      out_usr_eop   <= sel_usr_eop_s;
      out_usr_empty <= sel_usr_empty_s;
    end
  end

endmodule

// File: doc/bypass_nf_back.md
# bypass_nf_back

Packet-granular merge stage that sits directly downstream of the NF/bypass splitter. It takes two parallel stream triplets, each made of packet data, metadata and user/rule data. One triplet comes back from the network-function path (nf_*) and one from the bypass path (bypass_*). The block recombines them into a single triplet toward the egress stage, never interleaving beats of different packets across any of the three streams.

## Interface
Parameters:
- none; widths fixed by codebase: data 512, empty 6, metadata `metadata_t` from `struct_s.sv`.

Ports:
- clk  in  1  single clock for all logic
- rst  in  1  synchronous, active-high reset
- {nf,bypass}_pkt_{data,valid,sop,eop,empty}  in  512,1,1,1,6  packet stream per source
- {nf,bypass}_pkt_ready  out  1  packet beat accepted this cycle
- {nf,bypass}_meta_{data,valid}  in  metadata_t,1  one metadata word per packet
- {nf,bypass}_meta_ready  out  1  metadata accepted
- {nf,bypass}_usr_{data,valid,sop,eop,empty}  in  512,1,1,1,6  user/rule stream per source
- {nf,bypass}_usr_ready  out  1  usr beat accepted
- out_pkt_{data,valid,sop,eop,empty}  out  512,1,1,1,6  merged packet stream
- out_pkt_almost_full  in  1  downstream backpressure
- out_meta_{data,valid}  out  metadata_t,1  merged metadata
- out_meta_almost_full  in  1  downstream backpressure
- out_usr_{data,valid,sop,eop,empty}  out  512,1,1,1,6  merged usr stream
- out_usr_almost_full  in  1  downstream backpressure
- nf_pkt_cnt, bypass_pkt_cnt  out  32  packets completed per source, wrap at 2^32

## Operation
- State machine IDLE → MERGE → IDLE. Register `sel` (0=NF, 1=bypass) holds the locked source.
- IDLE:
  - All readies are 0. pkt_done, meta_done and usr_done are cleared.
  - Candidate sources are those with pkt_valid=1.
  - One candidate: lock it. Two: arbitrate per Configuration. Then go to MERGE.
- MERGE, per stream s ∈ {pkt, meta, usr}:
  - s_ready of the selected source = !s_done & !out_s_almost_full & !rst.
  - The unselected source's readies are 0.
  - A beat is transferred when valid & ready.
  - pkt_done sets on a transferred pkt beat with eop. meta_done sets on the first transferred meta word. usr_done sets on a transferred usr beat with eop.
- When pkt_done & meta_done & usr_done:
  - Increment the selected source's counter.
  - Update round-robin pointer (if enabled).
  - Return to IDLE.
- Every packet carries exactly one meta word and one usr message of ≥1 beat. sop/eop are forwarded unmodified; no framing repair is done.
- Each stream completes independently: meta may finish before or after the pkt beats, and the streams are not aligned beat-to-beat.
- Unselected source inputs are held untouched (ready=0) for the whole packet.

## Timing
- Reset values: all *_valid=0, all *_ready=0, state=IDLE, sel=0, done flags=0, both counters=0, RR pointer=NF. Data/sop/eop/empty outputs are don't-care.
- Output latency is 1 cycle: out_s_* registers the selected source's s fields on the cycle of transfer. out_s_valid=1 only for that transferred beat.
- IDLE→MERGE takes 1 cycle after pkt_valid is seen; readies can first assert in the MERGE cycle.
- MERGE→IDLE happens on the cycle after the last done flag sets. Minimum cost is N+2 cycles for an N-beat packet.
- Almost_full is sampled combinationally into ready. Downstream FIFOs must absorb ≥2 beats of skid after asserting almost_full.
- Simultaneous eop on pkt and usr with meta in the same cycle: all three done flags set together, and IDLE follows next cycle.
- Reset mid-packet: the partial packet is abandoned with no flush. Outputs go to reset values next cycle, and counters clear.

## Configuration
- `BYPASS_MERGE_RR_EN` defined: round-robin arbitration.
  - Priority goes to the source not served last.
  - The pointer toggles only on packet completion.
- Undefined: strict priority to NF.
  - Bypass is served only when nf_pkt_valid=0 in IDLE.
  - The RR pointer is not implemented.

## Test plan
- Single NF packet (3 pkt beats, 1 meta, 2 usr beats), no backpressure → identical beats on out_* with 1-cycle latency; nf_pkt_cnt=1; bypass sources see ready=0 throughout.
- Both sources valid every IDLE, 4 packets each:
  - with RR_EN, output order is NF,BYP,NF,BYP,…
  - without it, all 4 NF packets come first, then the 4 bypass packets.
  - Final counters are 4/4 in both cases.
- Meta arrives 5 cycles after pkt eop while usr finishes first → state stays MERGE until meta transfers; no other packet starts; counter increments once.
- out_pkt_almost_full=1 for cycles 3–7 of a 6-beat packet → nf_pkt_ready=0 those cycles; meta/usr keep flowing; all 6 beats are delivered in order with no loss or duplication.
- rst pulsed for 1 cycle mid-packet (beat 2 of 4) → all outputs/counters at reset values next cycle; a fresh packet afterwards merges correctly.
- Counter preloaded by forcing to 0xFFFF_FFFF, one packet completes → wraps to 0.
